bwn_coef_fetch: RTL and testbench

Address sequencer and output stage for the 3-bit binary-weight coefficient ROM. It walks ROM addresses 0..DEPTH-1 for a programmable number of passes and registers each returned coefficient. It presents the coefficients as a valid/ready stream to the downstream binary-weight MAC array. It sits directly upstream of the coefficient ROM's `addr` input and directly downstream of its combinational `coef` output.

---
 rtl/bwn_coef_fetch.sv | 172 +++++++++++++++++
 tb/tb_bwn_coef_fetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bwn_coef_fetch.sv
// bwn_coef_fetch: walks coefficient ROM addresses for num_pass passes and streams the
// registered coefficients downstream over valid/ready. Abort support: `define BWN_FETCH_ABORT_EN.
module bwn_coef_fetch #(
   parameter int WIDTH_A = 12,
   parameter int DEPTH   = 40
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [7:0]         num_pass,
   input  logic               abort,
   output logic [WIDTH_A-1:0] addr,
   input  logic [2:0]         coef_in,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [2:0]         m_coef,
   output logic               m_last,
   output logic               m_eos,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Wrap point is the last populated entry, not the counter's natural rollover.
   localparam logic [WIDTH_A-1:0] LAST_ADDR = WIDTH_A'(DEPTH - 1);
   localparam logic [WIDTH_A-1:0] ADDR_ONE  = WIDTH_A'(32'd1);

   state_t               state_r, state_s;
   logic [WIDTH_A-1:0]   addr_r, addr_s;
   logic [7:0]           pass_r, pass_s;
   logic [7:0]           npass_r, npass_s;
   logic                 valid_r, valid_s;
   logic [2:0]           coef_r, coef_s;
   logic                 last_r, last_s;
   logic                 eos_r, eos_s;
   logic                 busy_r, busy_s;
   logic                 done_r, done_s;
   logic                 load_s;
   logic                 at_end_s;
   logic                 final_s;
   logic                 abort_s;

`ifdef BWN_FETCH_ABORT_EN
   assign abort_s = abort && ((state_r == RUN) || (state_r == DRAIN));
`else
   logic unused_abort_s;
   assign unused_abort_s = abort;
   assign abort_s        = 1'b0;
`endif

   assign load_s   = (state_r == RUN) && (!valid_r || m_ready);
   assign at_end_s = (addr_r == LAST_ADDR);
   assign final_s  = at_end_s && (pass_r == (npass_r - 8'd1));

   // Next-state and next-register computation for the sequencer and output stage.
   always_comb begin
      state_s = state_r;
      addr_s  = addr_r;
      pass_s  = pass_r;
      npass_s = npass_r;
      valid_s = valid_r;
      coef_s  = coef_r;
      last_s  = last_r;
      eos_s   = eos_r;
      if (abort_s) begin
         state_s = IDLE;
         addr_s  = '0;
         valid_s = 1'b0;
         last_s  = 1'b0;
         eos_s   = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               addr_s = '0;
               if (start && (num_pass != 8'd0)) begin
                  npass_s = num_pass;
                  pass_s  = 8'd0;
                  state_s = RUN;
               end else if (start) begin
                  state_s = DONE;
               end else begin
                  state_s = IDLE;
               end
            end
            RUN: begin
               if (load_s) begin
                  valid_s = 1'b1;
                  coef_s  = coef_in;
                  last_s  = at_end_s;
                  eos_s   = final_s;
                  if (final_s) begin
                     addr_s  = '0;
                     state_s = DRAIN;
                  end else if (at_end_s) begin
                     addr_s = '0;
                     pass_s = pass_r + 8'd1;
                  end else begin
                     addr_s = addr_r + ADDR_ONE;
                  end
               end else begin
                  state_s = RUN;
               end
            end
            DRAIN: begin
               if (valid_r && m_ready) begin
                  valid_s = 1'b0;
                  state_s = DONE;
               end else begin
                  state_s = DRAIN;
               end
            end
            DONE: begin
               state_s = IDLE;
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
      busy_s = (state_s == RUN) || (state_s == DRAIN);
      done_s = (state_s == DONE);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Address, pass counters and registered output stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_r  <= '0;
         pass_r  <= 8'd0;
         npass_r <= 8'd0;
         valid_r <= 1'b0;
         coef_r  <= 3'd0;
         last_r  <= 1'b0;
         eos_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         addr_r  <= addr_s;
         pass_r  <= pass_s;
         npass_r <= npass_s;
         valid_r <= valid_s;
         coef_r  <= coef_s;
         last_r  <= last_s;
         eos_r   <= eos_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign addr    = addr_r;
   assign m_valid = valid_r;
   assign m_coef  = coef_r;
   assign m_last  = last_r;
   assign m_eos   = eos_r;
   assign busy    = busy_r;
   assign done    = done_r;

endmodule

// File: tb/tb_bwn_coef_fetch.sv
// Scoreboard bench for bwn_coef_fetch: stimulus pushes expected beats, a negedge monitor
// pops and compares every transfer, stall hold and done pulse.
module tb_bwn_coef_fetch;
   localparam int WA = 12;
   localparam int D  = 40;
   localparam logic [2:0] ROM [D] = '{
      3'd7, 3'd2, 3'd5, 3'd0, 3'd3, 3'd6, 3'd1, 3'd4, 3'd2, 3'd7,
      3'd0, 3'd5, 3'd3, 3'd1, 3'd6, 3'd4, 3'd7, 3'd2, 3'd0, 3'd5,
      3'd1, 3'd3, 3'd6, 3'd2, 3'd4, 3'd7, 3'd5, 3'd0, 3'd3, 3'd1,
      3'd6, 3'd2, 3'd7, 3'd4, 3'd0, 3'd5, 3'd1, 3'd3, 3'd6, 3'd4};

   logic          clk = 1'b0;
   logic          rst_n, start, abort, m_ready;
   logic [7:0]    num_pass;
   logic [WA-1:0] addr;
   logic [2:0]    coef_in, m_coef;
   logic          m_valid, m_last, m_eos, busy, done;

   int         n_chk = 0;
   int         n_pass = 0;
   logic [4:0] sb [$];
   bit         exp_done = 1'b0;
   int         done_cnt = 0;
   int         xfer_cnt = 0;
   int         cyc = 0;
   int         first_cyc = -1;
   int         last_cyc = -1;
   int         rdy_mode = 0;
   int         stall_left = 0;
   bit         stall_done = 1'b0;
   bit         stalled = 1'b0;
   logic [4:0] held = 5'd0;

   always #5 clk = ~clk;

   assign coef_in = (int'(addr) < D) ? ROM[int'(addr)] : 3'd0;

   bwn_coef_fetch #(.WIDTH_A(WA), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_pass(num_pass), .abort(abort),
      .addr(addr), .coef_in(coef_in), .m_valid(m_valid), .m_ready(m_ready),
      .m_coef(m_coef), .m_last(m_last), .m_eos(m_eos), .busy(busy), .done(done));

   task automatic chk(input string name, input int act, input int exp_v);
      n_chk++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
   endtask

   task automatic push_exp(input int np);
      for (int p = 0; p < np; p++)
         for (int a = 0; a < D; a++)
            sb.push_back({ROM[a], (a == D - 1), ((a == D - 1) && (p == np - 1))});
   endtask

   // Monitor: done pulses, transfers against the scoreboard, stall stability.
   always @(negedge clk) begin
      logic [4:0] e;
      cyc++;
      if (done) done_cnt++;
      if (exp_done) begin
         chk("done_pulse", done, 1);
         chk("busy_after_done", busy, 0);
         exp_done = 1'b0;
      end else if (done) begin
         chk("done_spurious", done, 0);
      end
      if (stalled) begin
         chk("stall_valid", m_valid, 1);
         chk("stall_hold", {m_coef, m_last, m_eos}, held);
      end
      if (m_valid && m_ready) begin
         if (sb.size() == 0) begin
            chk("beat_unexpected", 1, 0);
         end else begin
            e = sb.pop_front();
            chk($sformatf("beat%0d", xfer_cnt), {m_coef, m_last, m_eos}, e);
            if (e[0]) exp_done = 1'b1;
         end
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
         xfer_cnt++;
      end
      stalled = m_valid && !m_ready;
      held    = {m_coef, m_last, m_eos};
   end

   // Downstream ready driver: always ready, or random with one 5-cycle stall at beat 39.
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) m_ready = 1'b1;
         else if (stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
         end else if (xfer_cnt == 39 && !stall_done) begin
            stall_done = 1'b1;
            stall_left = 4;
            m_ready = 1'b0;
         end else m_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic run_seq(input int np, input int mode, input int restart_at, input int abort_at);
      int d0, k, budget;
      bit pr, pa;
      pr = 1'b0; pa = 1'b0;
      xfer_cnt = 0; first_cyc = -1; last_cyc = -1;
      stall_done = 1'b0; stall_left = 0; rdy_mode = mode;
      push_exp(np);
      d0 = done_cnt;
      @(posedge clk); #1 start = 1'b1; num_pass = 8'(np);
      @(posedge clk); #1 start = 1'b0; num_pass = 8'd0;
      if (np == 0) exp_done = 1'b1;
      else begin
         for (k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (m_valid) break;
         end
         chk("first_valid_latency", k, 2);
      end
      budget = 0;
      while (done_cnt == d0 && budget < 5000) begin
         @(posedge clk); #1;
         budget++;
         start = 1'b0; abort = 1'b0; num_pass = 8'd0;
         if (xfer_cnt == restart_at && !pr) begin start = 1'b1; num_pass = 8'd5; pr = 1'b1; end
         if (xfer_cnt == abort_at && !pa) begin abort = 1'b1; pa = 1'b1; end
      end
      start = 1'b0; abort = 1'b0;
      chk("seq_timeout", int'(budget < 5000), 1);
      chk("sb_empty", sb.size(), 0);
      if (mode == 0 && np != 0) chk("throughput", last_cyc - first_cyc + 1, np * D);
   endtask

   initial begin
      int budget, d0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_pass = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_addr", addr, 0);   chk("rst_valid", m_valid, 0); chk("rst_coef", m_coef, 0);
      chk("rst_last", m_last, 0); chk("rst_eos", m_eos, 0);     chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      run_seq(1, 0, -1, -1);
      run_seq(3, 0, -1, -1);
      run_seq(3, 1, -1, -1);
      run_seq(0, 0, -1, -1);
      run_seq(3, 0, 10, -1);

      // Reset in the middle of a pass, then a clean restart from address 0.
      xfer_cnt = 0; first_cyc = -1; rdy_mode = 0;
      push_exp(1);
      @(posedge clk); #1 start = 1'b1; num_pass = 8'd1;
      @(posedge clk); #1 start = 1'b0; num_pass = 8'd0;
      budget = 0;
      while (xfer_cnt < 17 && budget < 200) begin @(posedge clk); #1; budget++; end
      chk("reset_wait_timeout", int'(budget < 200), 1);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("mid_rst_addr", addr, 0);   chk("mid_rst_valid", m_valid, 0); chk("mid_rst_coef", m_coef, 0);
      chk("mid_rst_last", m_last, 0); chk("mid_rst_eos", m_eos, 0);     chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      sb.delete(); exp_done = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      run_seq(1, 0, -1, -1);

`ifdef BWN_FETCH_ABORT_EN
      xfer_cnt = 0; first_cyc = -1; rdy_mode = 0;
      push_exp(1);
      @(posedge clk); #1 start = 1'b1; num_pass = 8'd1;
      @(posedge clk); #1 start = 1'b0; num_pass = 8'd0;
      budget = 0;
      while (xfer_cnt < 25 && budget < 200) begin @(posedge clk); #1; budget++; end
      chk("abort_wait_timeout", int'(budget < 200), 1);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_valid", m_valid, 0); chk("abort_last", m_last, 0); chk("abort_eos", m_eos, 0);
      chk("abort_addr", addr, 0);     chk("abort_busy", busy, 0);
      sb.delete();
      d0 = done_cnt;
      repeat (4) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      run_seq(1, 0, -1, -1);
`else
      d0 = done_cnt;
      run_seq(1, 0, -1, 25);
      chk("abort_ignored_done", done_cnt - d0, 1);
`endif

      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
